// File: rtl/us_flow_packer.sv
// us_flow_packer
// Buffers 128-bit upstream timing-flow words in a FIFO and emits them as
// framed packets on an AXI-Stream style master: one header word
// {16'hEB90, seq, len, 80'h0} followed by len payload words.
// A packet starts when a full PKT_WORDS payload is buffered. A flush tick
// starts a shorter packet holding whatever is buffered at that point.
//
// Ports
//   sys_clk_i    : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   flow_vld_i   : upstream word valid
//   flow_i       : upstream word
//   prog_full_o  : registered occupancy >= PROG_FULL_THRESH
//   flush_i      : single-cycle request to close a short packet
//   m_tvalid_o   : packet stream valid
//   m_tdata_o    : packet stream data
//   m_tlast_o    : last word of packet
//   m_tready_i   : downstream ready
//   drop_cnt_o   : words dropped on a full buffer, saturating
//   pkt_seq_o    : sequence number of the next packet to be emitted
module us_flow_packer #(
    parameter int unsigned FIFO_DEPTH       = 512,
    parameter int unsigned PROG_FULL_THRESH = 448,
    parameter int unsigned PKT_WORDS        = 256
) (
    input  logic          sys_clk_i,
    input  logic          rst_i,
    input  logic          flow_vld_i,
    input  logic [127:0]  flow_i,
    output logic          prog_full_o,
    input  logic          flush_i,
    output logic          m_tvalid_o,
    output logic [127:0]  m_tdata_o,
    output logic          m_tlast_o,
    input  logic          m_tready_i,
    output logic [15:0]   drop_cnt_o,
    output logic [15:0]   pkt_seq_o
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] PKT_LEN  = OCC_W'(PKT_WORDS);
    localparam logic [OCC_W-1:0] PF_LEVEL = OCC_W'(PROG_FULL_THRESH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] seq;
        logic [15:0] len;
        logic [79:0] rsvd;
    } hdr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [OCC_W-1:0]  occ;
    logic              flush_pend;

    state_t            state;
    state_t            state_n;
    logic [OCC_W-1:0]  len;
    logic [OCC_W-1:0]  len_n;
    logic [OCC_W-1:0]  rem;
    logic [OCC_W-1:0]  rem_n;
    logic              tvalid_n;
    logic [DATA_W-1:0] tdata_n;
    logic              tlast_n;
    logic              pkt_start;
    logic              seq_inc;
    hdr_t              hdr;

    logic              wr_en;
    logic              rd_en;

    // Space is judged on the registered occupancy only; a same-cycle read never frees room.
    assign wr_en = flow_vld_i && (occ < OCC_FULL);
    assign rd_en = (state == S_PAYLOAD) && m_tvalid_o && m_tready_i;

    // The output register is always refilled one word ahead: the head word when
    // leaving the header, the word after the head when a payload word is accepted.
    assign rd_addr = (state == S_PAYLOAD) ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign rd_data = mem[rd_addr];

    // Buffer storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge sys_clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= flow_i;
        end
    end

    // Pointers, occupancy, drop counter, backpressure, flush latch and sequence.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            drop_cnt_o  <= '0;
            prog_full_o <= 1'b0;
            flush_pend  <= 1'b0;
            pkt_seq_o   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
            if (flow_vld_i && !wr_en && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            prog_full_o <= (occ >= PF_LEVEL);
            // A new tick wins over a same-cycle clear so it is kept for the next idle.
            if (flush_i) begin
                flush_pend <= 1'b1;
            end else if (pkt_start || ((state == S_IDLE) && (occ == '0))) begin
                flush_pend <= 1'b0;
            end
            if (seq_inc) begin
                pkt_seq_o <= pkt_seq_o + 16'd1;
            end
        end
    end

    // FSM state and registered stream outputs.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            len        <= '0;
            rem        <= '0;
            m_tvalid_o <= 1'b0;
            m_tdata_o  <= '0;
            m_tlast_o  <= 1'b0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            rem        <= rem_n;
            m_tvalid_o <= tvalid_n;
            m_tdata_o  <= tdata_n;
            m_tlast_o  <= tlast_n;
        end
    end

    // Next state and next output values; outputs only change when idle or on a handshake.
    always_comb begin
        state_n   = state;
        len_n     = len;
        rem_n     = rem;
        tvalid_n  = m_tvalid_o;
        tdata_n   = m_tdata_o;
        tlast_n   = m_tlast_o;
        pkt_start = 1'b0;
        seq_inc   = 1'b0;
        hdr       = '0;

        unique case (state)
            S_IDLE: begin
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                if (occ >= PKT_LEN) begin
                    pkt_start = 1'b1;
                    len_n     = PKT_LEN;
                end else if (flush_pend && (occ != '0)) begin
                    pkt_start = 1'b1;
                    len_n     = occ;
                end
                if (pkt_start) begin
                    hdr.sync = 16'hEB90;
                    hdr.seq  = pkt_seq_o;
                    hdr.len  = 16'(len_n);
                    state_n  = S_HEADER;
                    tvalid_n = 1'b1;
                    tdata_n  = hdr;
                end
            end
            S_HEADER: begin
                if (m_tready_i) begin
                    state_n = S_PAYLOAD;
                    tdata_n = rd_data;
                    tlast_n = (len == OCC_ONE);
                    rem_n   = len - OCC_ONE;
                end
            end
            S_PAYLOAD: begin
                if (m_tready_i) begin
                    if (m_tlast_o) begin
                        state_n  = S_IDLE;
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                        seq_inc  = 1'b1;
                    end else begin
                        tdata_n = rd_data;
                        tlast_n = (rem == OCC_ONE);
                        rem_n   = rem - OCC_ONE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_us_flow_packer.sv
// Directed bench for us_flow_packer: full packets, flush-closed packets,
// random backpressure, buffer overflow, mid-packet reset and sequence wrap.
module tb_us_flow_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic          flow_vld;
    logic [127:0]  flow;
    logic          prog_full;
    logic          flush;
    logic          m_tvalid;
    logic [127:0]  m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic [15:0]   drop_cnt;
    logic [15:0]   pkt_seq;

    logic          rdy_fix;
    logic          rand_rdy;
    logic          rnd_bit = 1'b1;

    int            n_cmp = 0;
    int            n_err = 0;

    logic [127:0]  q_data [$];
    logic          q_last [$];
    logic          stall_q = 1'b0;
    logic [127:0]  stall_d;
    logic          stall_l;

    us_flow_packer dut (
        .sys_clk_i   (clk),
        .rst_i       (rst),
        .flow_vld_i  (flow_vld),
        .flow_i      (flow),
        .prog_full_o (prog_full),
        .flush_i     (flush),
        .m_tvalid_o  (m_tvalid),
        .m_tdata_o   (m_tdata),
        .m_tlast_o   (m_tlast),
        .m_tready_i  (m_tready),
        .drop_cnt_o  (drop_cnt),
        .pkt_seq_o   (pkt_seq)
    );

    always #5 clk = ~clk;

    assign m_tready = rand_rdy ? rnd_bit : rdy_fix;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream monitor: records handshakes and checks that stalled words hold.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", 128'(m_tvalid), 128'(1));
                chk("stall_data", m_tdata, stall_d);
                chk("stall_last", 128'(m_tlast), 128'(stall_l));
            end
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_last.push_back(m_tlast);
            end
            stall_q = m_tvalid && !m_tready;
            stall_d = m_tdata;
            stall_l = m_tlast;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flow_vld = 1'b0;
        flush    = 1'b0;
        tick(2);
        rst = 1'b0;
        q_data.delete();
        q_last.delete();
        tick(1);
    endtask

    task automatic write_words(input int n, input logic [127:0] base);
        for (int i = 0; i < n; i++) begin
            flow_vld = 1'b1;
            flow     = base + 128'(i);
            tick(1);
        end
        flow_vld = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (q_data.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, 128'(q_data.size() >= n), 128'(1));
    endtask

    task automatic check_pkt(input int start, input logic [15:0] seq, input int len,
                             input logic [127:0] base, input string tag);
        logic [127:0] exp_hdr;
        exp_hdr = {16'hEB90, seq, 16'(len), 80'h0};
        if (q_data.size() < start + len + 1) begin
            chk({tag, "_size"}, 128'(q_data.size()), 128'(start + len + 1));
        end else begin
            chk({tag, "_hdr"}, q_data[start], exp_hdr);
            chk({tag, "_hdr_last"}, 128'(q_last[start]), 128'(0));
            for (int i = 0; i < len; i++) begin
                chk({tag, "_data"}, q_data[start + 1 + i], base + 128'(i));
                chk({tag, "_last"}, 128'(q_last[start + 1 + i]), 128'(i == len - 1));
            end
        end
    endtask

    initial begin
        int sent;
        int guard;

        rst      = 1'b1;
        flow_vld = 1'b0;
        flow     = '0;
        flush    = 1'b0;
        rdy_fix  = 1'b1;
        rand_rdy = 1'b0;
        tick(1);

        // Reset values
        chk("rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_tlast", 128'(m_tlast), 128'(0));
        chk("rst_tdata", m_tdata, 128'(0));
        chk("rst_prog_full", 128'(prog_full), 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        chk("rst_seq", 128'(pkt_seq), 128'(0));
        tick(1);
        rst = 1'b0;
        tick(1);

        // Full packet of 256 words
        write_words(256, 128'h0);
        wait_q(257, 300, "t34_wait");
        check_pkt(0, 16'h0000, 256, 128'h0, "t34");
        tick(5);
        chk("t34_seq", 128'(pkt_seq), 128'(1));
        chk("t34_count", 128'(q_data.size()), 128'(257));

        // Short packet closed by flush, then a flush on an empty buffer
        do_reset();
        write_words(10, 128'h100);
        tick(20);
        chk("t35_no_early", 128'(q_data.size()), 128'(0));
        pulse_flush();
        wait_q(11, 50, "t35_wait");
        check_pkt(0, 16'h0000, 10, 128'h100, "t35");
        tick(5);
        chk("t35_seq", 128'(pkt_seq), 128'(1));
        q_data.delete();
        q_last.delete();
        pulse_flush();
        tick(20);
        chk("t35_empty_flush", 128'(q_data.size()), 128'(0));
        chk("t35_seq_hold", 128'(pkt_seq), 128'(1));

        // Three packets under random backpressure
        do_reset();
        rand_rdy = 1'b1;
        sent  = 0;
        guard = 0;
        while (sent < 768 && guard < 20000) begin
            if (!prog_full) begin
                flow_vld = 1'b1;
                flow     = 128'(sent);
                sent++;
            end else begin
                flow_vld = 1'b0;
            end
            tick(1);
            guard++;
        end
        flow_vld = 1'b0;
        chk("t36_sent", 128'(sent), 128'(768));
        wait_q(771, 10000, "t36_wait");
        rand_rdy = 1'b0;
        check_pkt(0, 16'h0000, 256, 128'd0, "t36_p0");
        check_pkt(257, 16'h0001, 256, 128'd256, "t36_p1");
        check_pkt(514, 16'h0002, 256, 128'd512, "t36_p2");
        tick(5);
        chk("t36_drop", 128'(drop_cnt), 128'(0));
        chk("t36_seq", 128'(pkt_seq), 128'(3));

        // Overflow with the sink stalled
        do_reset();
        rdy_fix = 1'b0;
        write_words(447, 128'd0);
        tick(2);
        chk("t37_pf_447", 128'(prog_full), 128'(0));
        write_words(1, 128'd447);
        tick(2);
        chk("t37_pf_448", 128'(prog_full), 128'(1));
        write_words(72, 128'd448);
        tick(2);
        chk("t37_drop", 128'(drop_cnt), 128'(8));
        chk("t37_pf_full", 128'(prog_full), 128'(1));
        chk("t37_hdr_valid", 128'(m_tvalid), 128'(1));
        chk("t37_hdr_data", m_tdata, {16'hEB90, 16'h0000, 16'h0100, 80'h0});
        rdy_fix = 1'b1;
        wait_q(514, 1200, "t37_wait");
        tick(20);
        chk("t37_total", 128'(q_data.size()), 128'(514));
        check_pkt(0, 16'h0000, 256, 128'd0, "t37_p0");
        check_pkt(257, 16'h0001, 256, 128'd256, "t37_p1");
        chk("t37_pf_drained", 128'(prog_full), 128'(0));
        chk("t37_drop_hold", 128'(drop_cnt), 128'(8));

        // Reset in the middle of a packet
        do_reset();
        rdy_fix = 1'b1;
        write_words(256, 128'd0);
        wait_q(101, 400, "t38_wait");
        chk("t38_pre_word", m_tdata, 128'd100);
        rst = 1'b1;
        #1;
        chk("t38_tvalid", 128'(m_tvalid), 128'(0));
        chk("t38_tlast", 128'(m_tlast), 128'(0));
        chk("t38_tdata", m_tdata, 128'(0));
        chk("t38_prog_full", 128'(prog_full), 128'(0));
        chk("t38_drop", 128'(drop_cnt), 128'(0));
        chk("t38_seq", 128'(pkt_seq), 128'(0));
        tick(2);
        rst = 1'b0;
        q_data.delete();
        q_last.delete();
        tick(20);
        chk("t38_no_stale", 128'(q_data.size()), 128'(0));
        write_words(256, 128'h1000);
        wait_q(257, 300, "t38_wait2");
        check_pkt(0, 16'h0000, 256, 128'h1000, "t38");
        tick(5);
        chk("t38_seq_after", 128'(pkt_seq), 128'(1));

        // Sequence number wrap
        do_reset();
        force dut.pkt_seq_o = 16'hFFFF;
        tick(1);
        release dut.pkt_seq_o;
        tick(1);
        chk("t39_seq_forced", 128'(pkt_seq), 128'(16'hFFFF));
        write_words(3, 128'h2000);
        pulse_flush();
        wait_q(4, 50, "t39_wait");
        check_pkt(0, 16'hFFFF, 3, 128'h2000, "t39");
        tick(3);
        chk("t39_seq_wrap", 128'(pkt_seq), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/us_flow_packer.md
US_FLOW_PACKER -- requirements
Module: us_flow_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 512, buffer depth in 128-bit words (power of 2).
REQ-002 SHALL have parameter PROG_FULL_THRESH, default 448, occupancy at or above which prog_full_o asserts.
REQ-003 SHALL have parameter PKT_WORDS, default 256, payload words per full packet (1..FIFO_DEPTH-1).
REQ-004 sys_clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 flow_vld_i  input  1  upstream timing-flow word valid.
REQ-007 flow_i  input  128  upstream timing-flow word.
REQ-008 prog_full_o  output  1  backpressure to the upstream forwarding stage.
REQ-009 flush_i  input  1  single-cycle pulse (25 ms tick) requesting that a short packet be closed.
REQ-010 m_tvalid_o  output  1  packet stream valid.
REQ-011 m_tdata_o  output  128  packet stream data.
REQ-012 m_tlast_o  output  1  last word of packet.
REQ-013 m_tready_i  input  1  downstream ready.
REQ-014 drop_cnt_o  output  16  words dropped on full buffer, saturating.
REQ-015 pkt_seq_o  output  16  sequence number of the next packet to be emitted.

Function
REQ-016 SHALL write flow_i into the internal FIFO in any cycle with flow_vld_i=1 and occupancy < FIFO_DEPTH; a concurrent read does not free space for the write in the same cycle.
REQ-017 SHALL discard flow_i when flow_vld_i=1 and occupancy = FIFO_DEPTH, and increment drop_cnt_o, saturating at 0xFFFF.
REQ-018 SHALL register prog_full_o = (occupancy >= PROG_FULL_THRESH), updated one cycle after the occupancy change.
REQ-019 Occupancy SHALL be clog2(FIFO_DEPTH)+1 bits wide, incremented on write, decremented on payload handshake, and unchanged on simultaneous write and read.
REQ-020 SHALL latch flush_i into flush_pend; flush_pend clears when a packet starts, or in S_IDLE when occupancy = 0.
REQ-021 FSM states: S_IDLE, S_HEADER, S_PAYLOAD.
REQ-022 S_IDLE -> S_HEADER when occupancy >= PKT_WORDS (len = PKT_WORDS); otherwise, when flush_pend=1 and occupancy > 0 (len = occupancy sampled that cycle).
REQ-023 In S_HEADER, SHALL drive m_tvalid_o=1, m_tlast_o=0 and m_tdata_o = {16'hEB90, pkt_seq_o, len[15:0], 80'h0}, then move to S_PAYLOAD on handshake.
REQ-024 In S_PAYLOAD, SHALL present FIFO words in write order with m_tvalid_o=1, and assert m_tlast_o on the len-th word.
REQ-025 On the tlast handshake, SHALL return to S_IDLE and increment pkt_seq_o, wrapping 0xFFFF -> 0x0000.
REQ-026 While m_tvalid_o=1 and m_tready_i=0, m_tdata_o and m_tlast_o SHALL hold stable; m_tvalid_o SHALL never deassert before the handshake.
REQ-027 Sustained throughput SHALL be one word per cycle with m_tready_i held high; S_IDLE costs at most one cycle between packets.
REQ-028 A flush_i arriving during S_HEADER or S_PAYLOAD SHALL not alter the packet in flight; it applies at the next S_IDLE.
REQ-029 The packet length SHALL be fixed at S_IDLE exit; words written during a packet belong to later packets.
REQ-030 m_tvalid_o SHALL be 0 in S_IDLE.

Reset
REQ-031 Asserting rst_i SHALL immediately force S_IDLE, empty the FIFO (occupancy 0), and clear flush_pend.
REQ-032 Reset values: m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, prog_full_o=0, drop_cnt_o=0, pkt_seq_o=0.
REQ-033 Reset mid-packet SHALL abandon the packet; after release, no stale payload or tlast may appear.

Verification
REQ-034 Write 256 words 0..255 with tready=1 -> header EB90_0000_0100_0..., then words 0..255, tlast on word 255, pkt_seq_o=1.
REQ-035 Write 10 words, then a flush_i pulse -> header with len=0x000A, 10 payload words, tlast on the 10th; flush with an empty FIFO -> no output.
REQ-036 tready toggling pseudo-randomly at 50% over 3 full packets -> no data loss or duplication, data stable while stalled, pkt_seq 0,1,2.
REQ-037 tready=0, write 520 words -> prog_full_o=1 when occupancy reaches 448, occupancy saturates at 512, drop_cnt_o=8.
REQ-038 Assert rst_i during payload word 100 -> outputs at reset values the same cycle; after release, 256 new words produce a clean packet with seq 0.
REQ-039 Force pkt_seq to 0xFFFF and send one packet -> header seq field 0xFFFF, after which pkt_seq_o=0x0000.
